// File: rtl/dbg_disp_pkg.sv
// Shared constants and types for the debug seven-segment display scanner.
package dbg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a} codes, index 15 (F) on the left down to 0 on the right.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment code.
module hex_to_seg7
  import dbg_disp_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg_c
);

  assign o_seg_c = HEX_SEG[i_hex];

endmodule

// File: rtl/debug_display_scanner.sv
// Scans four 16-bit debug words as hex onto a 4-digit common-anode display,
// with manual/auto word selection, anti-ghost blanking and per-scan snapshots.
module debug_display_scanner
  import dbg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned ROTATE_SCANS = 1000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] word0,
  input  logic [15:0] word1,
  input  logic [15:0] word2,
  input  logic [15:0] word3,
  input  logic        auto_mode,
  input  logic [1:0]  sel,
  input  logic        freeze,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  cur_word
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned ROT_W = $clog2(ROTATE_SCANS) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [ROT_W-1:0] ROT_LAST  = ROT_W'(ROTATE_SCANS - 1);

  logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
  digit_idx_t       r_digit, w_digit_nxt;
  digit_idx_t       r_word_idx, w_idx_nxt;
  logic [ROT_W-1:0] r_rot_cnt, w_rot_nxt;
  logic             r_auto, w_auto_nxt;
  logic [15:0]      r_snapshot, w_snap_nxt;

  logic             w_tick;
  logic             w_scan_end;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg_c;
  logic [3:0]       w_an_nxt;
  logic             w_dp_nxt;

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_scan_end = w_tick && (r_digit == 2'd3);

  // Next-state: divider, digit, word scheduling and snapshot.
  always_comb begin
    w_div_nxt   = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    w_digit_nxt = w_tick ? r_digit + 2'd1 : r_digit;
    w_idx_nxt   = r_word_idx;
    w_rot_nxt   = r_rot_cnt;
    w_auto_nxt  = r_auto;
    w_snap_nxt  = r_snapshot;

    if (w_scan_end) begin
      w_auto_nxt = auto_mode;
      if (!auto_mode) begin
        w_idx_nxt = sel;
      end else if (!r_auto) begin
        // Entering auto: restart the dwell count on the word already shown.
        w_rot_nxt = '0;
      end else if (r_rot_cnt == ROT_LAST) begin
        w_rot_nxt = '0;
        w_idx_nxt = r_word_idx + 2'd1;
      end else begin
        w_rot_nxt = r_rot_cnt + ROT_W'(1);
      end

      if (!freeze) begin
        case (w_idx_nxt)
          2'd0:    w_snap_nxt = word0;
          2'd1:    w_snap_nxt = word1;
          2'd2:    w_snap_nxt = word2;
          default: w_snap_nxt = word3;
        endcase
      end
    end
  end

  assign w_nibble = r_snapshot[{r_digit, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex   (w_nibble),
    .o_seg_c (w_seg_c)
  );

  // Display drive derived from the current scan state.
  always_comb begin
    w_an_nxt = AN_OFF;
    w_dp_nxt = 1'b1;
    if (r_div_cnt >= BLANK_END) begin
      w_an_nxt = ~(4'b0001 << r_digit);
    end
    if (r_digit == r_word_idx) begin
      w_dp_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_div_cnt  <= '0;
      r_digit    <= '0;
      r_word_idx <= '0;
      r_rot_cnt  <= '0;
      r_auto     <= 1'b0;
      r_snapshot <= 16'h0000;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      cur_word   <= 2'd0;
    end else begin
      r_div_cnt  <= w_div_nxt;
      r_digit    <= w_digit_nxt;
      r_word_idx <= w_idx_nxt;
      r_rot_cnt  <= w_rot_nxt;
      r_auto     <= w_auto_nxt;
      r_snapshot <= w_snap_nxt;
      an         <= w_an_nxt;
      seg        <= w_seg_c;
      dp         <= w_dp_nxt;
      cur_word   <= r_word_idx;
    end
  end

endmodule

// File: tb/tb_debug_display_scanner.sv
// Scoreboard bench for debug_display_scanner against a cycle-count reference model.
module tb_debug_display_scanner;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int RS = 2;
  localparam int SCAN = 4 * SD;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] cur;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] word [4];
  logic        auto_mode;
  logic [1:0]  sel;
  logic        freeze;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  cur_word;

  debug_display_scanner #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL),
    .ROTATE_SCANS (RS)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .word0     (word[0]),
    .word1     (word[1]),
    .word2     (word[2]),
    .word3     (word[3]),
    .auto_mode (auto_mode),
    .sel       (sel),
    .freeze    (freeze),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .cur_word  (cur_word)
  );

  always #5 CLK = ~CLK;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: cycles since reset plus scheduling state.
  int          m_t;
  int          m_idx;
  int          m_rot;
  bit          m_auto;
  logic [15:0] m_snap;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int dv, dg, nib;
    logic [3:0] a;
    dv  = m_t % SD;
    dg  = (m_t / SD) % 4;
    nib = int'((m_snap >> (4 * dg)) & 16'hF);
    a   = 4'b1111;
    if (dv >= BL) a[dg] = 1'b0;
    e.an  = a;
    e.seg = hex_tab[nib];
    e.dp  = (dg == m_idx) ? 1'b0 : 1'b1;
    e.cur = 2'(m_idx);
    return e;
  endfunction

  function automatic void model_update();
    bit boundary;
    if (!Reset) begin
      m_t = 0; m_idx = 0; m_rot = 0; m_auto = 0; m_snap = 16'h0;
      return;
    end
    boundary = ((m_t % SCAN) == SCAN - 1);
    m_t++;
    if (boundary) begin
      if (auto_mode) begin
        if (!m_auto) m_rot = 0;
        else if (m_rot == RS - 1) begin
          m_rot = 0;
          m_idx = (m_idx + 1) % 4;
        end else m_rot++;
        m_auto = 1;
      end else begin
        m_idx  = int'(sel);
        m_auto = 0;
      end
      if (!freeze) m_snap = word[m_idx];
    end
  endfunction

  task automatic step();
    exp_t e;
    if (!Reset) e = '{4'hF, 7'h7F, 1'b1, 2'd0};
    else e = model_out();
    model_update();
    @(posedge CLK);
    #1;
    q.push_back(e);
  endtask

  task automatic run_to(int dg, int dv, int widx, string nm);
    int n;
    n = 0;
    while (!(((m_t / SD) % 4) == dg && (m_t % SD) == dv && (widx < 0 || m_idx == widx))) begin
      step();
      n++;
      if (n > 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: model never reached digit %0d div %0d", nm, dg, dv);
        return;
      end
    end
  endtask

  // Monitor: compare each registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", int'(an), int'(e.an));
        chk("seg", int'(seg), int'(e.seg));
        chk("dp", int'(dp), int'(e.dp));
        chk("cur_word", int'(cur_word), int'(e.cur));
      end
    end
  end

  initial begin
    Reset = 1'b0;
    word[0] = 16'h1234; word[1] = 16'h0; word[2] = 16'h0; word[3] = 16'h0;
    auto_mode = 1'b0; sel = 2'd0; freeze = 1'b0;
    m_t = 0; m_idx = 0; m_rot = 0; m_auto = 0; m_snap = 16'h0;

    repeat (3) step();
    Reset = 1'b1;
    repeat (4 * SCAN) step();

    sel = 2'd1;
    word[1] = 16'hFEDC; repeat (2 * SCAN) step();
    word[1] = 16'hBA98; repeat (2 * SCAN) step();
    word[1] = 16'h7654; repeat (2 * SCAN) step();
    word[1] = 16'h3210; repeat (2 * SCAN) step();

    word[0] = 16'hAAAA; word[1] = 16'hBBBB; word[2] = 16'hCCCC; word[3] = 16'hDDDD;
    auto_mode = 1'b1;
    repeat (12 * SCAN) step();

    auto_mode = 1'b0; sel = 2'd0;
    repeat (2 * SCAN) step();
    run_to(1, 4, -1, "sel_mid_scan");
    sel = 2'd2;
    repeat (3 * SCAN) step();

    sel = 2'd0; word[0] = 16'h1111;
    repeat (2 * SCAN) step();
    freeze = 1'b1; word[0] = 16'h2222;
    repeat (4 * SCAN) step();
    freeze = 1'b0;
    repeat (2 * SCAN) step();

    auto_mode = 1'b1;
    run_to(2, 3, 3, "reset_mid_digit2");
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    repeat (2 * SCAN) step();

    repeat (4000) begin
      if ($urandom_range(0, 63) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 255) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 199) == 0) freeze = ~freeze;
      if ($urandom_range(0, 15) == 0) word[$urandom_range(0, 3)] = 16'($urandom);
      Reset = ($urandom_range(0, 499) != 0);
      step();
    end
    Reset = 1'b1;

    repeat (3) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_display_scanner.md
Name: debug_display_scanner

Overview:
- Time-multiplexes four 16-bit debug words onto one 4-digit, common-anode seven-segment display as hexadecimal.
- Sits between the CPU debug/observation outputs and the board display pins.
- Schedules which word owns the display, either manually or by auto-rotation.
- Scans the four digits with anti-ghosting blanking and latches a tear-free snapshot once per scan.

Parameters:
SCAN_DIV, 100000, CLK cycles per digit period (min 4)
BLANK_CYCLES, 16, cycles at start of each digit period with all anodes off (must be < SCAN_DIV)
ROTATE_SCANS, 1000, full 4-digit scans per word in auto mode (min 1)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  reset; synchronous, active-low
word0  in  16  debug word 0
word1  in  16  debug word 1
word2  in  16  debug word 2
word3  in  16  debug word 3
auto_mode  in  1  1 = auto-rotate words, 0 = manual select
sel  in  2  manual word index
freeze  in  1  1 = hold current snapshot
an  out  4  digit anodes, active-low; an[0] = rightmost digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
cur_word  out  2  index of word currently displayed

Behaviour:
- Reset: Reset==0 at a rising edge forces the following on that edge, including mid-scan: div_cnt=0, digit=0, word_idx=0, rot_cnt=0, snapshot=16'h0000, an=4'b1111, seg=7'b1111111, dp=1, cur_word=0.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps to 0. tick = (div_cnt==SCAN_DIV-1).
- Digit sequence: on tick, digit advances 0→1→2→3→0.
- Scan boundary: a tick with digit==3 (wrap to 0).
- Snapshot: on each scan boundary, if freeze==0, snapshot ← word[next word_idx].
  - freeze==1 holds snapshot; word_idx and rotation still update.
- Manual mode (auto_mode==0): on each scan boundary, word_idx ← sel. sel changes mid-scan are ignored until the boundary.
- Auto mode (auto_mode==1): on each scan boundary, rot_cnt increments.
  - When rot_cnt reaches ROTATE_SCANS-1, rot_cnt ← 0 and word_idx ← word_idx+1, wrapping 3→0.
- Mode changes are sampled only at scan boundaries.
  - Manual→auto: rot_cnt ← 0 and rotation starts from the current word_idx.
  - Auto→manual: word_idx ← sel.
- Output register: an/seg/dp/cur_word are registered, with a 1-cycle latency from the div_cnt/digit/snapshot/word_idx state.
  - Blank phase (div_cnt < BLANK_CYCLES): an=4'b1111.
  - Otherwise: an = ~(4'b0001 << digit).
  - seg = hex decode of snapshot[4*digit+3 : 4*digit], in both phases.
  - dp=0 when digit==word_idx, else 1; this marks the active word on the display.
  - cur_word = word_idx.
- Hex encoding, {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events: tick, scan boundary and rotation can coincide on one edge. All updates apply on that same edge; the snapshot uses the post-update word_idx.
- Widths: div_cnt is $clog2(SCAN_DIV) bits; rot_cnt is $clog2(ROTATE_SCANS)+1 bits. No other arithmetic.

Decomposition:
- Shared package dbg_disp_pkg:
  - SEG_BLANK (7'b1111111) and AN_OFF (4'b1111) constants
  - typedef digit_idx_t [1:0]
  - 16-entry hex-to-seg constant table
- One sub-module, hex_to_seg7: combinational 4-bit hex in → 7-bit active-low seg out. Instantiated once and fed by a digit mux.

Test Plan:
All cases use SCAN_DIV=8, BLANK_CYCLES=2, ROTATE_SCANS=2.
1. Reset low 3 cycles, then high; word0=16'h1234, auto_mode=0, sel=0 → an=1111 seg=1111111 dp=1 cur_word=0 during reset. After the first scan boundary, digits show 4,3,2,1 (an 1110,1101,1011,0111) each for 6 cycles preceded by 2 blank cycles; dp=0 only on digit 0.
2. Full hex decode: word1=16'hFEDC, sel=1, then 16'hBA98, 16'h7654, 16'h3210 → every seg code matches the table; cur_word=1; dp=0 on digit 1.
3. Auto rotation: auto_mode=1, distinct words 16'hAAAA/BBBB/CCCC/DDDD → cur_word steps 0→1→2→3→0 every 2 scans (64 cycles). Snapshot changes only at scan boundaries.
4. Mid-scan sel change: sel 0→2 during digit 1 → display unchanged until the next 3→0 wrap, then shows word2. No torn digits.
5. Freeze: freeze=1, then word0 changes 16'h1111→16'h2222 → display holds 1111 indefinitely. freeze=0 → 2222 appears after the next scan boundary.
6. Reset asserted mid-digit-2 in auto mode with word_idx=3 → next edge gives an=1111, cur_word=0, snapshot 0. After release, the scan restarts at digit 0.
